mem_arbiter: RTL and testbench

Two-port, round-robin arbiter that shares the layer's single `mem_ctrl` instance between the layer controller and a second local requester (sensor DMA or test port). It sits between the requesters and `mem_ctrl` in the layer wrapper. On every side it uses the same 4-phase REQ/ACK handshake that `mem_ctrl` already uses. Each transaction is latched at grant, so a requester's bus is sampled exactly once.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arb_rr.sv | 23 ++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
//  mem_arbiter_pkg
//  Shared widths, state encodings and the latched-transaction record for the
//  two-port memory arbiter.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

  localparam int LC_MEM_ADDR_WIDTH = 32;
  localparam int LC_MEM_DATA_WIDTH = 32;
  localparam int AW = LC_MEM_ADDR_WIDTH - 2;
  localparam int DW = LC_MEM_DATA_WIDTH;

  localparam logic [1:0] MARB_IDLE = 2'd0;
  localparam logic [1:0] MARB_MREQ = 2'd1;
  localparam logic [1:0] MARB_MREL = 2'd2;
  localparam logic [1:0] MARB_CACK = 2'd3;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_txn_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ----------------------------------------------------------------------------
//  mem_arb_rr
//  Combinational 2-way round-robin picker: a tie goes to the port not served
//  last.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
//  mem_arbiter
//  Round-robin arbiter sharing one mem_ctrl between two 4-phase REQ/ACK
//  requesters; the winner's bus is latched once at grant.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          P0_REQ,
  input  logic          P0_WRITE,
  input  logic [AW-1:0] P0_ADDR,
  input  logic [DW-1:0] P0_DIN,
  input  logic          P1_REQ,
  input  logic          P1_WRITE,
  input  logic [AW-1:0] P1_ADDR,
  input  logic [DW-1:0] P1_DIN,
  output logic          P0_ACK,
  output logic          P1_ACK,
  output logic [DW-1:0] RD_DATA,
  output logic          MEM_REQ_OUT,
  output logic          MEM_WRITE,
  output logic [AW-1:0] MEM_AOUT,
  output logic [DW-1:0] MEM_DOUT,
  input  logic [DW-1:0] MEM_DIN,
  input  logic          MEM_ACK_IN,
  output logic          GRANT,
  output logic          BUSY,
  output logic          TIMEOUT_ERR
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  mem_txn_t      txn_q, txn_d;
  logic          mem_req_q, mem_req_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [1:0]    ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    req_vec;
  logic          arb_valid;
  logic          arb_winner;
  logic [7:0]    cnt_inc;

  assign req_vec = {P1_REQ, P0_REQ};
  assign cnt_inc = cnt_q + 8'd1;

  mem_arb_rr u_rr (
    .req    (req_vec),
    .last   (last_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    txn_d     = txn_q;
    mem_req_d = mem_req_q;
    rd_data_d = rd_data_q;
    ack_d     = ack_q;
    timeout_d = 1'b0;

    case (state_q)
      MARB_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          if (arb_winner) begin
            txn_d.write = P1_WRITE;
            txn_d.addr  = P1_ADDR;
            txn_d.data  = P1_DIN;
          end else begin
            txn_d.write = P0_WRITE;
            txn_d.addr  = P0_ADDR;
            txn_d.data  = P0_DIN;
          end
          cnt_d     = 8'd0;
          mem_req_d = 1'b1;
          state_d   = MARB_MREQ;
        end
      end
      MARB_MREQ: begin
        cnt_d = cnt_inc;
        // A late acknowledge on the same edge as the limit still wins.
        if (MEM_ACK_IN) begin
          rd_data_d = MEM_DIN;
          mem_req_d = 1'b0;
          state_d   = MARB_MREL;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          rd_data_d = '1;
          timeout_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = MARB_MREL;
        end
      end
      MARB_MREL: begin
        if (!MEM_ACK_IN) begin
          ack_d[grant_q] = 1'b1;
          state_d        = MARB_CACK;
        end
      end
      MARB_CACK: begin
        if (!req_vec[grant_q]) begin
          ack_d   = 2'b00;
          last_d  = grant_q;
          state_d = MARB_IDLE;
        end
      end
      default: state_d = MARB_IDLE;
    endcase

    busy_d = (state_d != MARB_IDLE);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= MARB_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      txn_q     <= '0;
      mem_req_q <= 1'b0;
      rd_data_q <= '0;
      ack_q     <= 2'b00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      txn_q     <= txn_d;
      mem_req_q <= mem_req_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign P0_ACK      = ack_q[0];
  assign P1_ACK      = ack_q[1];
  assign RD_DATA     = rd_data_q;
  assign MEM_REQ_OUT = mem_req_q;
  assign MEM_WRITE   = txn_q.write;
  assign MEM_AOUT    = txn_q.addr;
  assign MEM_DOUT    = txn_q.data;
  assign GRANT       = grant_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
//  tb_mem_arbiter
//  Scoreboard bench: requesters and a mem_ctrl model push expectations,
//  a monitor checks every acknowledge. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 4;

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;
  typedef struct { int p; logic [DW-1:0] rd; } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p_req [2];
  logic          p_write [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_din [2];
  logic          p0_ack, p1_ack, mem_req, mem_write, mem_ack, grant, busy, to_err;
  logic [DW-1:0] rd_data, mem_dout, mem_din;
  logic [AW-1:0] mem_aout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [1:0] req_snap = 2'b00;

  int mode = 0;                 // 0 random mem_ctrl, 1 directed, 2 silent
  logic force_to = 1'b0;
  logic [DW-1:0] forced_data = '0;
  int model_last = 1;
  logic sb_on = 1'b0;
  txn_t pend0 [$];
  txn_t pend1 [$];
  exp_t exp_q [$];
  logic prev0 = 1'b0, prev1 = 1'b0;

  mem_arbiter #(.MEM_TIMEOUT(TO)) dut (
    .CLK(clk), .RESETn(rst_n),
    .P0_REQ(p_req[0]), .P0_WRITE(p_write[0]), .P0_ADDR(p_addr[0]), .P0_DIN(p_din[0]),
    .P1_REQ(p_req[1]), .P1_WRITE(p_write[1]), .P1_ADDR(p_addr[1]), .P1_DIN(p_din[1]),
    .P0_ACK(p0_ack), .P1_ACK(p1_ack), .RD_DATA(rd_data),
    .MEM_REQ_OUT(mem_req), .MEM_WRITE(mem_write), .MEM_AOUT(mem_aout),
    .MEM_DOUT(mem_dout), .MEM_DIN(mem_din), .MEM_ACK_IN(mem_ack),
    .GRANT(grant), .BUSY(busy), .TIMEOUT_ERR(to_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_snap <= {p_req[1], p_req[0]};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? p1_ack : p0_ack;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_p0_ack"}, p0_ack, 0);
    chk({tag, "_p1_ack"}, p1_ack, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_aout"}, mem_aout, 0);
    chk({tag, "_mem_dout"}, mem_dout, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, to_err, 0);
  endtask

  // mem_ctrl model: predicts the winner, checks the latched bus, answers.
  task automatic serve();
    int win, hi, dly, rel;
    logic to;
    logic [DW-1:0] data;
    txn_t t;
    exp_t e;
    win = (req_snap == 2'b11) ? 1 - model_last : (req_snap[1] ? 1 : 0);
    chk("grant", grant, 64'(win));
    chk("busy", busy, 1);
    chk("pending", (win == 1) ? pend1.size() : pend0.size(), 1);
    if (win == 1 && pend1.size() == 0) return;
    if (win == 0 && pend0.size() == 0) return;
    t = (win == 1) ? pend1.pop_front() : pend0.pop_front();
    chk("mem_write", mem_write, 64'(t.w));
    chk("mem_aout", mem_aout, 64'(t.a));
    chk("mem_dout", mem_dout, 64'(t.d));
    model_last = win;
    if (mode == 1) begin
      to = force_to; dly = 0; rel = 0; data = forced_data;
    end else begin
      to = ($urandom_range(0, 5) == 0);
      dly = $urandom_range(0, 3);
      rel = $urandom_range(0, 2);
      data = $urandom();
    end
    e.p = win;
    e.rd = to ? {DW{1'b1}} : data;
    exp_q.push_back(e);
    hi = 0;
    if (to) begin
      for (int i = 0; i < TO + 8 && mem_req; i++) begin hi++; @(negedge clk); end
      chk("timeout_cycles", 64'(hi), 64'(TO));
      chk("timeout_err_on", to_err, 1);
      @(negedge clk);
      chk("timeout_err_off", to_err, 0);
    end else begin
      repeat (dly) @(negedge clk);
      mem_din = data;
      mem_ack = 1'b1;
      for (int i = 0; i < 20 && mem_req; i++) begin hi++; @(negedge clk); end
      chk("req_release", mem_req, 0);
      chk("no_timeout_err", to_err, 0);
      repeat (rel) @(negedge clk);
      mem_ack = 1'b0;
      mem_din = $urandom();
    end
  endtask

  initial begin
    mem_ack = 1'b0;
    mem_din = '0;
    forever begin
      @(negedge clk);
      if (mode != 2 && rst_n && mem_req) serve();
    end
  end

  // Monitor: every rising ACK retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_on && rst_n) begin
        if (p0_ack || p1_ack) begin
          chk("single_ack", {p0_ack, p1_ack} == 2'b11, 0);
          chk("ack_owner", grant, 64'(p1_ack));
        end
        if ((p0_ack && !prev0) || (p1_ack && !prev1)) begin
          chk("exp_queue", exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_port", 64'(p1_ack), 64'(e.p));
            chk("rd_data", rd_data, 64'(e.rd));
          end
        end
      end
      prev0 = p0_ack;
      prev1 = p1_ack;
    end
  end

  task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic early, output int lat);
    txn_t t;
    int c0;
    logic ok;
    t.w = w; t.a = a; t.d = d;
    lat = -1;
    p_write[p] = w; p_addr[p] = a; p_din[p] = d;
    if (p == 1) pend1.push_back(t); else pend0.push_back(t);
    p_req[p] = 1'b1;
    c0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = mem_req && busy && (int'(grant) == p);
    end
    chk("granted", ok, 1);
    if (!ok) begin p_req[p] = 1'b0; return; end
    // Scramble the bus: the arbiter must already have latched it.
    p_write[p] = 1'($urandom_range(0, 1));
    p_addr[p]  = AW'($urandom());
    p_din[p]   = $urandom();
    if (early) p_req[p] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = ack_of(p);
    end
    chk("ack_seen", ok, 1);
    lat = cyc - c0;
    if (!early) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      p_req[p] = 1'b0;
    end
    @(negedge clk);
    chk(early ? "early_ack_width" : "ack_release", ack_of(p), 0);
    chk("busy_after_ack", busy, 0);
  endtask

  task automatic rand_req(input int p, input int n);
    int lat;
    for (int k = 0; k < n; k++) begin
      do_txn(p, 1'($urandom_range(0, 1)), AW'($urandom()), $urandom(),
             ($urandom_range(0, 4) == 0), lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int lat, lat0, lat1;
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_din[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    sb_on = 1'b1;
    model_last = 1;
    @(negedge clk);

    mode = 1; force_to = 1'b0; forced_data = 32'hDEADBEEF;
    fork
      do_txn(0, 1'b0, 30'h11, 32'hA5A5A5A5, 1'b0, lat0);
      do_txn(1, 1'b1, 30'h22, 32'h5A5A5A5A, 1'b0, lat1);
    join
    do_txn(0, 1'b0, 30'h05, 32'h0, 1'b0, lat);
    chk("single_read_latency", 64'(lat), 3);
    fork
      do_txn(0, 1'b0, 30'h33, 32'h1, 1'b0, lat0);
      do_txn(1, 1'b1, 30'h3F, 32'h12345678, 1'b0, lat1);
    join
    force_to = 1'b1;
    do_txn(1, 1'b0, 30'h07, 32'h0, 1'b0, lat);
    force_to = 1'b0;
    do_txn(0, 1'b0, 30'h09, 32'h0, 1'b1, lat);

    mode = 0;
    fork
      rand_req(0, 40);
      rand_req(1, 40);
    join
    chk("exp_queue_drained", exp_q.size(), 0);

    mode = 2; sb_on = 1'b0;
    @(negedge clk);
    p_addr[0] = 30'h15; p_req[0] = 1'b1;
    @(negedge clk);
    chk("rst_test_mreq", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    p_req[0] = 1'b0;
    p_write[1] = 1'b1; p_addr[1] = 30'h3F; p_din[1] = 32'h12345678; p_req[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    pend0.delete(); pend1.delete(); exp_q.delete();
    @(negedge clk);
    chk("post_reset_grant", grant, 1);
    chk("post_reset_req", mem_req, 1);
    chk("post_reset_aout", mem_aout, 64'h3F);
    chk("post_reset_dout", mem_dout, 64'h12345678);
    chk("post_reset_write", mem_write, 1);
    rst_n = 1'b0;
    p_req[1] = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
